bcd_conv: RTL and testbench

Sequential 32-bit binary-to-BCD converter placed directly downstream of the `pow` unit. It takes the 32-bit `result` and `Oflag` outputs and produces ten packed BCD digits for the display/readout stage. Conversion uses shift-and-add-3 (double dabble), one bit per clock. The `start`/`ready` handshake matches the level protocol of `pow`, so `pow.ready` can drive `start` directly.

---
 rtl/bcd_conv_if.sv | 21 ++
 rtl/bcd_conv.sv | 127 ++++++++++++
 tb/tb_bcd_conv.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_if.sv
// Handshake and data bundle between a requester (e.g. pow) and bcd_conv.
// master drives the request side; slave is the converter.
interface bcd_conv_if;
  logic        start;
  logic [31:0] value;
  logic        oflag;
  logic        ready;
  logic        busy;
  logic [39:0] bcd;
  logic        err;

  modport master (
    output start, value, oflag,
    input  ready, busy, bcd, err
  );

  modport slave (
    input  start, value, oflag,
    output ready, busy, bcd, err
  );
endinterface

// File: rtl/bcd_conv.sv
// Sequential 32-bit binary to 10-digit BCD converter (double dabble, one bit per clock).
// Optional macro BCD_CONV_OFLAG_ERR_EN: oflag at acceptance yields an all-F error marker.
module bcd_conv (
  input  logic        clk,
  input  logic        rst,
  bcd_conv_if.slave   s
);

  localparam int unsigned BIN_W = 32;
  localparam int unsigned DIG_N = 10;
  localparam int unsigned BCD_W = 4 * DIG_N;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;

`ifndef BCD_CONV_OFLAG_ERR_EN
  logic unused_oflag;
  assign unused_oflag = s.oflag;
`endif

  // Add-3 correction on every nibble >= 5, then shift the next binary bit in.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIG_N; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (s.start) begin
          sr_d    = s.value;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = SHIFT;
`ifdef BCD_CONV_OFLAG_ERR_EN
          if (s.oflag) begin
            bcd_d   = '1;
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end

      SHIFT: begin
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bcd_d   = acc_shift;
          state_d = DONE;
        end
      end

      DONE: begin
        if (!s.start) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == DONE);
    busy_d  = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign s.ready = ready_q;
  assign s.busy  = busy_q;
  assign s.bcd   = bcd_q;
  assign s.err   = err_q;

endmodule

// File: tb/tb_bcd_conv.sv
// Self-checking bench for bcd_conv: cycle-level reference model plus directed vectors.
module tb_bcd_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bcd_conv_if bus ();

  bcd_conv dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits by repeated division.
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(t % 32'd10);
      t = t / 32'd10;
    end
    return r;
  endfunction

  // Reference model: 0 idle, 1 converting, 2 done.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [39:0] m_pend  = '0;
  logic [39:0] m_bcd   = '0;
  logic        m_err   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_bcd   = '0;
      m_err   = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
`ifdef BCD_CONV_OFLAG_ERR_EN
             if (bus.oflag) begin
               m_phase = 2;
               m_bcd   = '1;
               m_err   = 1'b1;
             end else
`endif
             begin
               m_phase = 1;
               m_cnt   = 0;
               m_pend  = to_bcd(bus.value);
               m_err   = 1'b0;
             end
           end
        1: begin
             m_cnt++;
             if (m_cnt == 32) begin
               m_phase = 2;
               m_bcd   = m_pend;
             end
           end
        default: if (!bus.start) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 40'(bus.ready), 40'(m_phase == 2));
      chk("cyc_busy",  40'(bus.busy),  40'(m_phase == 1));
      chk("cyc_bcd",   bus.bcd, m_bcd);
      chk("cyc_err",   40'(bus.err),   40'(m_err));
    end
  end

  // Request at a negedge; measure edges after acceptance until ready.
  task automatic do_conv(input string name, input logic [31:0] v, input logic of,
                         input logic [39:0] exp_bcd, input logic exp_err, input int exp_k);
    int k;
    bit seen;
    bus.value = v;
    bus.oflag = of;
    bus.start = 1'b1;
    @(posedge clk);
    k = 0;
    @(negedge clk);
    seen = bus.ready;
    bus.value = ~v;
    bus.oflag = ~of;
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      seen = bus.ready;
    end
    chk({name, "_latency"}, 40'(k), 40'(exp_k));
    chk({name, "_bcd"}, bus.bcd, exp_bcd);
    chk({name, "_err"}, 40'(bus.err), 40'(exp_err));
  endtask

  task automatic release_start(input string name, input logic [39:0] exp_bcd);
    bus.start = 1'b0;
    bus.oflag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_ready_drop"}, 40'(bus.ready), 40'h0);
    chk({name, "_bcd_hold"}, bus.bcd, exp_bcd);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.value = '0;
    bus.oflag = 1'b0;
    rst = 1'b1;

    chk("model_3125", to_bcd(32'd3125), 40'h0000003125);
    chk("model_max",  to_bcd(32'hFFFFFFFF), 40'h4294967295);
    chk("model_zero", to_bcd(32'd0), 40'h0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 40'(bus.ready), 40'h0);
    chk("rst_busy",  40'(bus.busy),  40'h0);
    chk("rst_bcd",   bus.bcd, 40'h0);
    chk("rst_err",   40'(bus.err),   40'h0);
    rst = 1'b0;
    @(negedge clk);

    do_conv("v3125", 32'd3125, 1'b0, 40'h0000003125, 1'b0, 32);
    release_start("v3125", 40'h0000003125);
    do_conv("v9261", 32'd9261, 1'b0, 40'h0000009261, 1'b0, 32);
    release_start("v9261", 40'h0000009261);
    do_conv("v0", 32'd0, 1'b0, 40'h0, 1'b0, 32);
    release_start("v0", 40'h0);
    do_conv("vmax", 32'hFFFFFFFF, 1'b0, 40'h4294967295, 1'b0, 32);

    // Held start in DONE must not retrigger.
    bus.value = 32'd7;
    repeat (50) @(negedge clk);
    chk("hold_ready", 40'(bus.ready), 40'h1);
    chk("hold_bcd", bus.bcd, 40'h4294967295);
    release_start("vmax", 40'h4294967295);
    do_conv("v7", 32'd7, 1'b0, 40'h0000000007, 1'b0, 32);
    release_start("v7", 40'h0000000007);

    // Reset in the middle of a conversion.
    bus.value = 32'd123456789;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 40'(bus.ready), 40'h0);
    chk("midrst_busy",  40'(bus.busy),  40'h0);
    chk("midrst_bcd",   bus.bcd, 40'h0);
    chk("midrst_err",   40'(bus.err),   40'h0);
    rst = 1'b0;
    @(negedge clk);
    do_conv("v123456789", 32'd123456789, 1'b0, 40'h0123456789, 1'b0, 32);
    release_start("v123456789", 40'h0123456789);

`ifdef BCD_CONV_OFLAG_ERR_EN
    do_conv("oflag5", 32'd5, 1'b1, 40'hFFFFFFFFFF, 1'b1, 0);
    release_start("oflag5", 40'hFFFFFFFFFF);
`else
    do_conv("oflag5", 32'd5, 1'b1, 40'h0000000005, 1'b0, 32);
    release_start("oflag5", 40'h0000000005);
`endif
    do_conv("v5", 32'd5, 1'b0, 40'h0000000005, 1'b0, 32);
    release_start("v5", 40'h0000000005);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
